pe_dbuf: RTL and testbench

Parametrised weight-stationary processing element for the systolic array. Each cycle it performs one signed fixed-point multiply-accumulate: `input_in × active_weight + psum_in`. The weight is double-buffered, so the next tile's weights shift in down the column while the current tile computes, and a one-cycle `switch` commits them. Valid tags travel with the data, and a sticky overflow flag reports arithmetic overflow.

---
 rtl/pe_pkg.sv | 16 +
 rtl/fxp_mac.sv | 46 ++++
 rtl/pe_dbuf.sv | 82 ++++++++
 tb/tb_pe_dbuf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the weight-stationary processing element.
// Default fixed-point format and the signed clamp limits used when PE_SAT_EN is defined.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_FRAC_BITS  = 8;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Combinational signed fixed-point multiply-accumulate: (a*b >>> FRAC_BITS) + c.
// Reduction to DATA_WIDTH bits clamps when PE_SAT_EN is defined, otherwise wraps.
module fxp_mac
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int FRAC_BITS  = PE_FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    output logic        [DATA_WIDTH-1:0] result,
    output logic                         overflow
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [PW:0]   sum;
    logic [PW-DATA_WIDTH+1:0] top_bits;

    assign prod    = a * b;
    assign shifted = prod >>> FRAC_BITS;
    // One extra bit of headroom so the add itself can never overflow.
    assign sum     = {shifted[PW-1], shifted} + {{(PW-DATA_WIDTH+1){c[DATA_WIDTH-1]}}, c};

    // The result fits iff every bit above the target sign bit matches it.
    assign top_bits = sum[PW:DATA_WIDTH-1];
    assign overflow = !((&top_bits) || !(|top_bits));

`ifdef PE_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

    always_comb begin
        result = sum[DATA_WIDTH-1:0];
        if (overflow) begin
            result = sum[PW] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign result = sum[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/pe_dbuf.sv
// Weight-stationary systolic PE with a double-buffered weight and sticky overflow flag.
// Build option PE_SAT_EN selects saturating result reduction (default: wrap).
module pe_dbuf
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int FRAC_BITS  = PE_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] input_in,
    input  logic [DATA_WIDTH-1:0] psum_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  weight_shift,
    input  logic                  switch_in,
    input  logic                  ovf_clr,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] input_out,
    output logic [DATA_WIDTH-1:0] psum_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  switch_out,
    output logic                  ovf_sticky
);

    logic [DATA_WIDTH-1:0] shadow_w;
    logic [DATA_WIDTH-1:0] active_w;
    logic [DATA_WIDTH-1:0] mac_result;
    logic                  mac_ovf;

    fxp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .a        (input_in),
        .b        (active_w),
        .c        (psum_in),
        .result   (mac_result),
        .overflow (mac_ovf)
    );

    // Switch copies the pre-edge shadow, so a same-cycle shift never leaks through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            if (weight_shift) shadow_w <= weight_in;
            if (switch_in)    active_w <= shadow_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            input_out  <= '0;
            psum_out   <= '0;
            switch_out <= 1'b0;
        end else begin
            valid_out  <= valid_in;
            switch_out <= switch_in;
            if (valid_in) begin
                input_out <= input_in;
                psum_out  <= mac_result;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (valid_in && mac_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign weight_out = shadow_w;

endmodule

// File: tb/tb_pe_dbuf.sv
// Randomized and directed bench for pe_dbuf against an arithmetic reference model.
module tb_pe_dbuf;

    localparam int W = 16;
    localparam int F = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in;
    logic [W-1:0] input_in;
    logic [W-1:0] psum_in;
    logic [W-1:0] weight_in;
    logic         weight_shift;
    logic         switch_in;
    logic         ovf_clr;
    logic         valid_out;
    logic [W-1:0] input_out;
    logic [W-1:0] psum_out;
    logic [W-1:0] weight_out;
    logic         switch_out;
    logic         ovf_sticky;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] m_shadow, m_active, m_in, m_psum;
    logic         m_valid, m_sw, m_ovf;

    always #5 clk = ~clk;

    pe_dbuf #(.DATA_WIDTH(W), .FRAC_BITS(F)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .input_in     (input_in),
        .psum_in      (psum_in),
        .weight_in    (weight_in),
        .weight_shift (weight_shift),
        .switch_in    (switch_in),
        .ovf_clr      (ovf_clr),
        .valid_out    (valid_out),
        .input_out    (input_out),
        .psum_out     (psum_out),
        .weight_out   (weight_out),
        .switch_out   (switch_out),
        .ovf_sticky   (ovf_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_mac(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] c,
                                    output logic [W-1:0] r, output logic o);
        longint p, s;
        p = longint'($signed(a)) * longint'($signed(b));
        s = (p >>> F) + longint'($signed(c));
        o = (s > 32767) || (s < -32768);
`ifdef PE_SAT_EN
        if (s > 32767)       r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
        else                 r = s[15:0];
`else
        r = s[15:0];
`endif
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_in = '0; m_psum = '0;
        m_valid = 1'b0; m_sw = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_out"},  32'(valid_out),  32'(m_valid));
        chk({tag, ".input_out"},  32'(input_out),  32'(m_in));
        chk({tag, ".psum_out"},   32'(psum_out),   32'(m_psum));
        chk({tag, ".weight_out"}, 32'(weight_out), 32'(m_shadow));
        chk({tag, ".switch_out"}, 32'(switch_out), 32'(m_sw));
        chk({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(m_ovf));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at the next negedge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] c, input logic sh, input logic [W-1:0] w,
                        input logic sw, input logic clr);
        logic [W-1:0] r;
        logic o;
        valid_in = v; input_in = a; psum_in = c;
        weight_shift = sh; weight_in = w; switch_in = sw; ovf_clr = clr;
        @(posedge clk);
        ref_mac(a, m_active, c, r, o);
        if (sw) m_active = m_shadow;
        if (sh) m_shadow = w;
        if (v) begin
            m_psum = r;
            m_in   = a;
        end
        if (v && o)   m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_valid = v;
        m_sw    = sw;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] held_psum, held_in, rc;
        rst_n = 1'b0;
        valid_in = 1'b0; input_in = '0; psum_in = '0; weight_in = '0;
        weight_shift = 1'b0; switch_in = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic MAC: 1.5 * 2.0 + 1.0 = 4.0
        step("load2",  0, 16'h0, 16'h0, 1, 16'h0200, 0, 0);
        step("sw2",    0, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        step("basic",  1, 16'h0180, 16'h0100, 0, 16'h0, 0, 0);
        chk("basic.psum_lit", 32'(psum_out), 32'h0400);
        chk("basic.in_lit",   32'(input_out), 32'h0180);

        // Overlap: shift 1.0 while streaming with 2.0, then switch
        step("ovl_shift", 1, 16'h0100, 16'h0000, 1, 16'h0100, 0, 0);
        chk("ovl.weight_out", 32'(weight_out), 32'h0100);
        chk("ovl.psum_old_w", 32'(psum_out), 32'h0200);
        step("ovl_swN",   1, 16'h0100, 16'h0000, 0, 16'h0, 1, 0);
        chk("ovl.edgeN", 32'(psum_out), 32'h0200);
        step("ovl_N1",    1, 16'h0100, 16'h0000, 0, 16'h0, 0, 0);
        chk("ovl.edgeN1", 32'(psum_out), 32'h0100);

        // Simultaneous shift and switch
        step("ld3",   0, 16'h0, 16'h0, 1, 16'h0300, 0, 0);
        step("shsw",  0, 16'h0, 16'h0, 1, 16'h0500, 1, 0);
        chk("shsw.shadow", 32'(weight_out), 32'h0500);
        chk("shsw.swout",  32'(switch_out), 32'h1);
        step("use3",  1, 16'h0100, 16'h0000, 0, 16'h0, 0, 0);
        chk("shsw.active", 32'(psum_out), 32'h0300);

        // Overflow and sticky behaviour
        step("ld2b",  0, 16'h0, 16'h0, 1, 16'h0200, 0, 0);
        step("sw2b",  0, 16'h0, 16'h0, 0, 16'h0, 1, 0);
        step("ovf",   1, 16'h7F00, 16'h0000, 0, 16'h0, 0, 0);
`ifdef PE_SAT_EN
        chk("ovf.psum_lit", 32'(psum_out), 32'h7FFF);
`else
        chk("ovf.psum_lit", 32'(psum_out), 32'hFE00);
`endif
        chk("ovf.flag", 32'(ovf_sticky), 32'h1);
        step("ovf_hold", 1, 16'h0010, 16'h0010, 0, 16'h0, 0, 0);
        step("ovf_setwins", 1, 16'h7F00, 16'h0000, 0, 16'h0, 0, 1);
        chk("ovf.setwins", 32'(ovf_sticky), 32'h1);
        step("ovf_clr", 0, 16'h0, 16'h0, 0, 16'h0, 0, 1);
        chk("ovf.cleared", 32'(ovf_sticky), 32'h0);

        // Gap handling
        step("pre_gap", 1, 16'h0123, 16'h0045, 0, 16'h0, 0, 0);
        held_psum = psum_out;
        held_in   = input_out;
        for (int i = 0; i < 3; i++) begin
            step("gap", 0, 16'($urandom), 16'($urandom), 0, 16'h0, 0, 0);
        end
        chk("gap.psum_hold", 32'(psum_out), 32'(held_psum));
        chk("gap.in_hold",   32'(input_out), 32'(held_in));

        // Randomized streaming
        for (int i = 0; i < 300; i++) begin
            logic v, sh, sw, clr;
            v   = ($urandom_range(0, 3) != 0);
            sh  = ($urandom_range(0, 3) == 0);
            sw  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step("rnd", v, 16'($urandom), 16'($urandom), sh, 16'($urandom), sw, clr);
        end

        // Asynchronous reset mid-stream
        step("pre_rst_ld", 1, 16'h0200, 16'h0100, 1, 16'h0400, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        rc = 16'($urandom);
        step("post_rst", 1, 16'h1234, rc, 0, 16'h0, 0, 0);
        chk("post_rst.psum_eq_in", 32'(psum_out), 32'(rc));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
